jk_bank_driver: RTL and testbench
=================================

// Module: jk_bank_driver
// PURPOSE
//  Drive side for a bank of WIDTH JK flip-flops. Accepts a target word over a
//  valid/ready handshake and computes per-bit J/K excitation from the JK
//  excitation table. The bank is clocked on the same clk and reaches the target
//  on the next edge. With readback enabled, the block checks the bank output
//  ff_q against the target and retries on mismatch.
// PARAMETERS
//  WIDTH        8  number of JK flip-flops in the driven bank
//  MAX_RETRY    2  extra DRIVE attempts after a readback mismatch (0 = none)
//  TOGGLE_MODE  0  0: set/reset excitation; 1: toggle excitation (J=K=1 on change)
// PORTS
//  clk        in   1      rising-edge clock; one clock domain only
//  rst        in   1      reset; synchronous, active-low
//  tgt_valid  in   1      target word valid
//  tgt_ready  out  1      block idle, can accept a target (high only in IDLE)
//  tgt_data   in   WIDTH  requested next state of the bank
//  ff_q       in   WIDTH  bank outputs (readback); ignored without the macro
//  j          out  WIDTH  J drive to the bank
//  k          out  WIDTH  K drive to the bank
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle pulse: target reached
//  err        out  1      one-cycle pulse: retries exhausted, target not reached
// BEHAVIOUR
//  - Reset (rst=0 at an edge): state=IDLE, j=k=0, done=err=0, busy=0,
//    retry count=0, shadow=0, target register=0. tgt_ready=1 after the reset edge.
//    Reset overrides any state, and any in-flight target is discarded.
//  - Handshake: transfer happens on an edge with tgt_valid & tgt_ready. tgt_data
//    is latched on that edge. tgt_valid while busy is ignored; the source holds
//    its data until accepted.
//  - Current state cur = ff_q with the macro, or shadow without it.
//  - Excitation (TOGGLE_MODE=0), per bit cur->tgt:
//    0->0 J0K0; 0->1 J1K0; 1->0 J0K1; 1->1 J0K0. Don't-cares resolve to 0.
//    J=K=1 is never produced.
//  - Excitation (TOGGLE_MODE=1): j = k = cur ^ tgt.
//  - j and k are non-zero only during DRIVE. All other states drive j=k=0,
//    so the bank holds.
//  - FSM with the macro: IDLE -> DRIVE (1 cycle) -> SETTLE (1) -> CHECK (1) -> IDLE.
//    CHECK compares ff_q == target:
//      match: done=1 in the next cycle, which is back in IDLE.
//      mismatch and retry count < MAX_RETRY: retry count +1, go to DRIVE.
//        Excitation is recomputed from the new ff_q.
//      mismatch otherwise: err=1 in the next cycle (IDLE), retry count=0.
//  - Latency (accept edge at T0): DRIVE during T0+1; done/tgt_ready high at T0+4.
//  - Target equal to current: still walks DRIVE with j=k=0 at the same latency.
//  - done and err are never high together. A new target can be accepted on the
//    same edge that ends the done/err cycle.
//  - Retry count width is clog2(MAX_RETRY+1), min 1. It clears on every accept.
// CONFIGURATION
//  JK_READBACK_CHECK_EN defined:
//    FSM includes SETTLE and CHECK. cur = ff_q. Retry/err path is active.
//  Not defined:
//    IDLE -> DRIVE -> IDLE. On exiting DRIVE, shadow <= target and done=1 next
//    cycle (latency T0+2). cur = shadow. ff_q is unused. err is tied 0.
// TESTING
//  1 rst=0 2 cycles -> j=k=0, done=err=busy=0, tgt_ready=1.
//  2 Bank 0x00, send 0xA5 (TOGGLE_MODE=0) -> T0+1 j=0xA5 k=0x00; ff_q=0xA5;
//    done pulse at T0+4 (T0+2 without macro).
//  3 Bank 0xA5, send 0x5A (TOGGLE_MODE=1) -> DRIVE j=k=0xFF; done, ff_q=0x5A.
//    Resend 0x5A -> j=k=0x00, done at the same latency.
//  4 Macro on, bench forces bank bit0 stuck-at-0, MAX_RETRY=2, send 0x01 ->
//    3 DRIVE cycles each j=0x01, then err pulse, no done, tgt_ready=1.
//  5 rst=0 during SETTLE -> next cycle IDLE, j=k=0, no done/err; a following
//    target completes normally.
//  6 tgt_valid held high with 0x33 while busy -> accepted only on the edge
//    ending the done cycle of the prior target; exactly one transfer.

Source files
------------

// File: rtl/jk_bank_driver.sv
// Drive side for a bank of WIDTH JK flip-flops: accepts a target word and applies J/K excitation.
// Define JK_READBACK_CHECK_EN to add the readback check (SETTLE/CHECK states) with retry and err.
module jk_bank_driver #(
  parameter int WIDTH       = 8,
  parameter int MAX_RETRY   = 2,
  parameter int TOGGLE_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] ff_q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] cur;
  logic             accept;
  logic             set_done;

  assign tgt_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = tgt_valid & tgt_ready;

`ifdef JK_READBACK_CHECK_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  logic [RW-1:0] retry_cnt;
  logic          set_err;
  logic          retry_inc;

  assign cur = ff_q;
`else
  // Without readback the block trusts that the bank reached the last target.
  logic [WIDTH-1:0] shadow;
  logic             unused_ff_q;

  assign cur         = shadow;
  assign unused_ff_q = ^ff_q;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    set_done  = 1'b0;
    j         = '0;
    k         = '0;
`ifdef JK_READBACK_CHECK_EN
    set_err   = 1'b0;
    retry_inc = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) state_nxt = DRIVE;
      end
      DRIVE: begin
        // Set/reset excitation never produces J=K=1; toggle mode only flips changed bits.
        if (TOGGLE_MODE != 0) begin
          j = cur ^ target;
          k = cur ^ target;
        end else begin
          j = ~cur & target;
          k = cur & ~target;
        end
`ifdef JK_READBACK_CHECK_EN
        state_nxt = SETTLE;
`else
        state_nxt = IDLE;
        set_done  = 1'b1;
`endif
      end
`ifdef JK_READBACK_CHECK_EN
      SETTLE: begin
        state_nxt = CHECK;
      end
      CHECK: begin
        state_nxt = IDLE;
        if (ff_q == target) begin
          set_done = 1'b1;
        end else if (retry_cnt < RETRY_LIMIT) begin
          retry_inc = 1'b1;
          state_nxt = DRIVE;
        end else begin
          set_err = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      target <= '0;
      done   <= 1'b0;
`ifdef JK_READBACK_CHECK_EN
      err       <= 1'b0;
      retry_cnt <= '0;
`else
      shadow <= '0;
`endif
    end else begin
      state <= state_nxt;
      done  <= set_done;
      if (accept) target <= tgt_data;
`ifdef JK_READBACK_CHECK_EN
      err <= set_err;
      if (accept || set_err) retry_cnt <= '0;
      else if (retry_inc)    retry_cnt <= retry_cnt + RW'(1);
`else
      if (state == DRIVE) shadow <= target;
`endif
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: set/reset and toggle instances share stimulus, each drives a modelled JK bank.
// Adapts latency and the stuck-bit retry test to whether JK_READBACK_CHECK_EN is defined.
module tb_jk_bank_driver;
  localparam int WIDTH = 8;
`ifdef JK_READBACK_CHECK_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [7:0] tgt;
    logic [7:0] j0;
    logic [7:0] k0;
    logic [7:0] j1;
    logic [7:0] k1;
    int         drives;
  } vec_t;

  typedef struct {
    logic       is_err;
    logic [7:0] bank;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tgt_valid;
  logic [7:0] tgt_data;
  logic [7:0] bank0, bank1;
  logic       stuck0;
  logic       tgt_ready0, busy0, done0, err0;
  logic       tgt_ready1, busy1, done1, err1;
  logic [7:0] j0, k0, j1, k1;

  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRY(2), .TOGGLE_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready0), .tgt_data(tgt_data),
    .ff_q(bank0), .j(j0), .k(k0), .busy(busy0), .done(done0), .err(err0)
  );

  jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRY(2), .TOGGLE_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready1), .tgt_data(tgt_data),
    .ff_q(bank1), .j(j1), .k(k1), .busy(busy1), .done(done1), .err(err1)
  );

  // JK bank model; stuck0 pins bit 0 of both banks low.
  always @(posedge clk) begin
    if (!rst) begin
      bank0 <= '0;
      bank1 <= '0;
    end else begin
      bank0 <= ((j0 & ~bank0) | (~k0 & bank0)) & {7'h7F, ~stuck0};
      bank1 <= ((j1 & ~bank1) | (~k1 & bank1)) & {7'h7F, ~stuck0};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done/err pulse consumes one expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done0 || err0 || done1 || err1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_completion: got done0=%b err0=%b done1=%b err1=%b, expected none",
                 done0, err0, done1, err1);
      end else begin
        e = sb_q.pop_front();
        checkOutput("sb_done0", 32'(done0), 32'(!e.is_err));
        checkOutput("sb_err0", 32'(err0), 32'(e.is_err));
        checkOutput("sb_done1", 32'(done1), 32'(!e.is_err));
        checkOutput("sb_err1", 32'(err1), 32'(e.is_err));
        if (!e.is_err) begin
          checkOutput("sb_bank0", 32'(bank0), 32'(e.bank));
          checkOutput("sb_bank1", 32'(bank1), 32'(e.bank));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge of the done/err cycle.
  task automatic applyStimulus(input logic [7:0] tgt, input logic [7:0] ej0, input logic [7:0] ek0,
                               input logic [7:0] ej1, input logic [7:0] ek1, input logic is_err,
                               input int lat, input int drives);
    int   waited;
    int   cyc;
    int   dcnt;
    exp_t e;
    waited = 0;
    while (!tgt_ready0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_before_send", 32'(tgt_ready0), 32'd1);
    tgt_valid = 1'b1;
    tgt_data  = tgt;
    e.is_err  = is_err;
    e.bank    = tgt;
    sb_q.push_back(e);
    @(negedge clk);
    tgt_valid = 1'b0;
    checkOutput("drive_busy0", 32'(busy0), 32'd1);
    checkOutput("drive_j0", 32'(j0), 32'(ej0));
    checkOutput("drive_k0", 32'(k0), 32'(ek0));
    checkOutput("drive_j1", 32'(j1), 32'(ej1));
    checkOutput("drive_k1", 32'(k1), 32'(ek1));
    dcnt = 0;
    cyc  = 1;
    while (!(done0 || err0) && cyc < 40) begin
      if (busy0 && (j0 != 8'h00 || k0 != 8'h00)) dcnt++;
      @(negedge clk);
      cyc++;
    end
    checkOutput("latency", 32'(cyc), 32'(lat));
    checkOutput("drive_cycles", 32'(dcnt), 32'(drives));
    checkOutput("ready_at_end", 32'(tgt_ready0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   extra;
    exp_t e;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    tgt_valid = 1'b0;
    tgt_data  = '0;
    stuck0    = 1'b0;

    vecs[0] = '{8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hA5, 1};
    vecs[1] = '{8'h5A, 8'h5A, 8'hA5, 8'hFF, 8'hFF, 1};
    vecs[2] = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 0};
    vecs[3] = '{8'hFF, 8'hA5, 8'h00, 8'hA5, 8'hA5, 1};
    vecs[4] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1};
    vecs[5] = '{8'h3C, 8'h3C, 8'h00, 8'h3C, 8'h3C, 1};

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_j0", 32'(j0), 32'd0);
    checkOutput("rst_k0", 32'(k0), 32'd0);
    checkOutput("rst_done0", 32'(done0), 32'd0);
    checkOutput("rst_err0", 32'(err0), 32'd0);
    checkOutput("rst_busy0", 32'(busy0), 32'd0);
    checkOutput("rst_ready0", 32'(tgt_ready0), 32'd1);
    checkOutput("rst_j1", 32'(j1), 32'd0);
    checkOutput("rst_busy1", 32'(busy1), 32'd0);
    rst = 1'b1;

    foreach (vecs[i])
      applyStimulus(vecs[i].tgt, vecs[i].j0, vecs[i].k0, vecs[i].j1, vecs[i].k1, 1'b0, LAT, vecs[i].drives);

`ifdef JK_READBACK_CHECK_EN
    // Bit 0 stuck low: three DRIVE attempts, then err
    stuck0 = 1'b1;
    applyStimulus(8'h3D, 8'h01, 8'h00, 8'h01, 8'h01, 1'b1, 10, 3);
    checkOutput("stuck_bank0", 32'(bank0), 32'h3C);
    stuck0 = 1'b0;
`endif

    // Reset in the middle of a transfer discards it
    tgt_valid = 1'b1;
    tgt_data  = 8'h7E;
    @(negedge clk);
    tgt_valid = 1'b0;
`ifdef JK_READBACK_CHECK_EN
    @(negedge clk);
`endif
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy0", 32'(busy0), 32'd0);
    checkOutput("midrst_j0", 32'(j0), 32'd0);
    checkOutput("midrst_k0", 32'(k0), 32'd0);
    checkOutput("midrst_done0", 32'(done0), 32'd0);
    checkOutput("midrst_err0", 32'(err0), 32'd0);
    checkOutput("midrst_ready0", 32'(tgt_ready0), 32'd1);
    checkOutput("midrst_busy1", 32'(busy1), 32'd0);
    rst = 1'b1;
    applyStimulus(8'h81, 8'h81, 8'h00, 8'h81, 8'h81, 1'b0, LAT, 1);

    // Valid held through busy: second word accepted on the edge ending done
    tgt_valid = 1'b1;
    tgt_data  = 8'h0F;
    e.is_err  = 1'b0;
    e.bank    = 8'h0F;
    sb_q.push_back(e);
    @(negedge clk);
    checkOutput("hold_j0_a", 32'(j0), 32'h0E);
    checkOutput("hold_k0_a", 32'(k0), 32'h80);
    checkOutput("hold_j1_a", 32'(j1), 32'h8E);
    tgt_data = 8'h33;
    e.bank   = 8'h33;
    sb_q.push_back(e);
    repeat (LAT - 1) @(negedge clk);
    checkOutput("hold_done_a", 32'(done0), 32'd1);
    checkOutput("hold_ready_a", 32'(tgt_ready0), 32'd1);
    @(negedge clk);
    tgt_valid = 1'b0;
    checkOutput("hold_busy_b", 32'(busy0), 32'd1);
    checkOutput("hold_j0_b", 32'(j0), 32'h30);
    checkOutput("hold_k0_b", 32'(k0), 32'h0C);
    checkOutput("hold_j1_b", 32'(j1), 32'h3C);
    repeat (LAT - 1) @(negedge clk);
    checkOutput("hold_done_b", 32'(done0), 32'd1);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy0 || busy1) extra++;
    end
    checkOutput("hold_single_transfer", 32'(extra), 32'd0);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
